// File: rtl/tx_sched.sv
// rtl/tx_sched.sv - CPU-to-UART byte FIFO with handshake and inter-byte gap scheduling
module tx_sched #(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_wr,
  input  logic [7:0]               cpu_data,
  input  logic                     flush,
  input  logic                     tx_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  output logic                     cpu_stall,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  // The gap counter counts down to zero inclusive, so it is loaded one short.
  localparam logic [7:0]    GAP_LOAD = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      gap_q, gap_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      mem_q [DEPTH];
  logic            push;
  logic            pop;

  // Next-state logic: flush wins over everything, otherwise FIFO push/pop and the send FSM.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    gap_d      = gap_q;
    tx_data_d  = tx_data_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    pop        = 1'b0;

    if (flush) begin
      state_d    = IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      gap_d      = 8'd0;
      overflow_d = 1'b0;
    end else begin
      // A write is only taken when the count before the edge leaves room,
      // even if a pop frees a slot on the same edge.
      push = cpu_wr && (count_q != FULL);
      if (cpu_wr && (count_q == FULL)) begin
        overflow_d = 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            pop       = 1'b1;
            tx_data_d = mem_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + AW'(1);
            state_d   = SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (GAP_CYCLES == 0) begin
              state_d = IDLE;
            end else begin
              state_d = GAP;
              gap_d   = GAP_LOAD;
            end
          end
        end
        GAP: begin
          if (gap_q == 8'd0) begin
            state_d = IDLE;
          end else begin
            gap_d = gap_q - 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end

      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      gap_q      <= 8'd0;
      tx_data_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      gap_q      <= gap_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  // Byte storage; contents survive reset since the pointers make them unreachable.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem_q[wr_ptr_q] <= cpu_data;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = (state_q == SEND);
  assign cpu_stall  = (count_q == FULL);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_tx_sched.sv
// tb/tb_tx_sched.sv - self-checking bench for tx_sched against a queue-level reference model
module tb_tx_sched;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cpu_wr = 1'b0;
  logic [7:0] cpu_data = 8'h00;
  logic       flush = 1'b0;
  logic       tx_ready = 1'b0;

  logic [7:0] txd0, txd2;
  logic       txv0, txv2;
  logic       stall0, stall2;
  logic [4:0] cnt0, cnt2;
  logic       ovf0, ovf2;
  logic       busy0, busy2;

  tx_sched #(.DEPTH(DEPTH), .GAP_CYCLES(0)) u_g0 (
    .clk(clk), .reset(reset), .cpu_wr(cpu_wr), .cpu_data(cpu_data), .flush(flush),
    .tx_ready(tx_ready), .tx_data(txd0), .tx_valid(txv0), .cpu_stall(stall0),
    .fifo_count(cnt0), .overflow(ovf0), .busy(busy0)
  );

  tx_sched #(.DEPTH(DEPTH), .GAP_CYCLES(2)) u_g2 (
    .clk(clk), .reset(reset), .cpu_wr(cpu_wr), .cpu_data(cpu_data), .flush(flush),
    .tx_ready(tx_ready), .tx_data(txd2), .tx_valid(txv2), .cpu_stall(stall2),
    .fifo_count(cnt2), .overflow(ovf2), .busy(busy2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: index 0 has no gap, index 1 has a two-cycle gap.
  // Phase 0 = nothing on the line, 1 = byte offered, 2 = enforced silence.
  int         m_cnt [2];
  int         m_hd  [2];
  int         m_tl  [2];
  int         m_ph  [2];
  int         m_rem [2];
  int         m_ovf [2];
  logic [7:0] m_txd [2];
  logic [7:0] m_buf [2][DEPTH];

  task automatic model_step(input int i);
    int g;
    bit acc;
    bit took;
    g = (i == 0) ? 0 : 2;
    if (!reset) begin
      m_cnt[i] = 0; m_hd[i] = 0; m_tl[i] = 0; m_ph[i] = 0;
      m_rem[i] = 0; m_ovf[i] = 0; m_txd[i] = 8'h00;
    end else if (flush) begin
      m_cnt[i] = 0; m_hd[i] = 0; m_tl[i] = 0; m_ph[i] = 0;
      m_rem[i] = 0; m_ovf[i] = 0;
    end else begin
      acc  = cpu_wr && (m_cnt[i] < DEPTH);
      took = 1'b0;
      if (cpu_wr && !acc) m_ovf[i] = 1;
      if (m_ph[i] == 0) begin
        if (m_cnt[i] > 0) begin
          m_txd[i] = m_buf[i][m_hd[i]];
          m_hd[i]  = (m_hd[i] + 1) % DEPTH;
          m_ph[i]  = 1;
          took     = 1'b1;
        end
      end else if (m_ph[i] == 1) begin
        if (tx_ready) begin
          if (g == 0) m_ph[i] = 0;
          else begin
            m_ph[i]  = 2;
            m_rem[i] = g;
          end
        end
      end else begin
        m_rem[i] = m_rem[i] - 1;
        if (m_rem[i] == 0) m_ph[i] = 0;
      end
      if (acc) begin
        m_buf[i][m_tl[i]] = cpu_data;
        m_tl[i] = (m_tl[i] + 1) % DEPTH;
      end
      m_cnt[i] = m_cnt[i] + int'(acc) - int'(took);
    end
  endtask

  // Advance the model on each rising edge with the inputs the DUT samples.
  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic cmp(input int i, input logic v, input logic [7:0] d, input logic st,
                     input logic [4:0] c, input logic o, input logic b);
    string p;
    p = (i == 0) ? "g0" : "g2";
    chk({p, ".tx_valid"},   int'(v),  int'(m_ph[i] == 1));
    chk({p, ".tx_data"},    int'(d),  int'(m_txd[i]));
    chk({p, ".cpu_stall"},  int'(st), int'(m_cnt[i] == DEPTH));
    chk({p, ".fifo_count"}, int'(c),  m_cnt[i]);
    chk({p, ".overflow"},   int'(o),  m_ovf[i]);
    chk({p, ".busy"},       int'(b),  int'((m_ph[i] != 0) || (m_cnt[i] != 0)));
  endtask

  // Compare every output of both instances against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, txv0, txd0, stall0, cnt0, ovf0, busy0);
      cmp(1, txv2, txd2, stall2, cnt2, ovf2, busy2);
    end
  end

  // Record bytes handed over by the no-gap instance during the fill/drain scenario.
  bit         cap_en = 1'b0;
  int         ncap = 0;
  logic [7:0] cap [64];
  always @(posedge clk) begin
    if (cap_en && txv0 && tx_ready && ncap < 64) begin
      cap[ncap] = txd0;
      ncap++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    cpu_wr = 1'b0;
    flush = 1'b0;
    tx_ready = 1'b1;
    while ((busy0 || busy2) && n < budget) begin
      cyc();
      n++;
    end
    chk("drain_done", int'(busy0 || busy2), 0);
  endtask

  initial begin
    // Reset state
    reset = 1'b0;
    cyc();
    chk_en = 1'b1;
    cyc();
    chk("rst.tx_valid", int'(txv2), 0);
    chk("rst.tx_data", int'(txd2), 0);
    chk("rst.fifo_count", int'(cnt2), 0);
    chk("rst.busy", int'(busy2), 0);
    chk("rst.cpu_stall", int'(stall0), 0);
    chk("rst.overflow", int'(ovf0), 0);
    reset = 1'b1;
    cyc();

    // Single byte, minimum latency and two-cycle gap
    tx_ready = 1'b1;
    cpu_wr = 1'b1;
    cpu_data = 8'h41;
    cyc();
    cpu_wr = 1'b0;
    chk("lat.count_after_E", int'(cnt2), 1);
    cyc();
    chk("lat.valid_E1", int'(txv2), 1);
    chk("lat.data_E1", int'(txd2), 8'h41);
    cyc();
    chk("lat.valid_E2", int'(txv2), 0);
    chk("lat.g0_idle_E2", int'(busy0), 0);
    cyc();
    chk("lat.valid_E3", int'(txv2), 0);
    chk("lat.busy_E3", int'(busy2), 1);
    cyc();
    chk("lat.busy_E4", int'(busy2), 0);

    // Fill with the line stalled: 17 writes, 17th accepted since the head moved out
    tx_ready = 1'b0;
    for (int k = 0; k < 17; k++) begin
      cpu_wr = 1'b1;
      cpu_data = 8'(k);
      cyc();
    end
    chk("fill.count", int'(cnt0), 16);
    chk("fill.stall", int'(stall2), 1);
    chk("fill.overflow", int'(ovf2), 0);
    chk("fill.head", int'(txd0), 8'h00);
    cpu_data = 8'h11;
    cyc();
    chk("full.overflow", int'(ovf0), 1);
    chk("full.count", int'(cnt0), 16);

    // Handshake edge while full with a concurrent write
    cap_en = 1'b1;
    tx_ready = 1'b1;
    cpu_data = 8'h22;
    cyc();
    cpu_wr = 1'b0;
    chk("hs_full.count_g0", int'(cnt0), 16);
    chk("hs_full.count_g2", int'(cnt2), 16);
    chk("hs_full.overflow", int'(ovf2), 1);
    cyc();
    chk("hs_full.pop_g0", int'(cnt0), 15);
    chk("hs_full.next_g0", int'(txd0), 8'h01);
    chk("hs_full.gap_g2", int'(cnt2), 16);
    drain(400);
    cap_en = 1'b0;
    chk("order.len", ncap, 17);
    for (int k = 0; k < 17 && k < ncap; k++) begin
      chk($sformatf("order.byte%0d", k), int'(cap[k]), k);
    end

    // Flush with a write during SEND and five bytes queued
    tx_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cpu_wr = 1'b1;
      cpu_data = 8'(8'h30 + k);
      cyc();
    end
    chk("pre_flush.count", int'(cnt2), 5);
    chk("pre_flush.overflow", int'(ovf2), 1);
    flush = 1'b1;
    cpu_data = 8'h99;
    cyc();
    flush = 1'b0;
    cpu_wr = 1'b0;
    chk("flush.valid", int'(txv2), 0);
    chk("flush.count", int'(cnt2), 0);
    chk("flush.overflow", int'(ovf2), 0);
    chk("flush.busy", int'(busy0), 0);

    // Reset while in the gap with three bytes queued
    for (int k = 0; k < 4; k++) begin
      cpu_wr = 1'b1;
      cpu_data = 8'(8'h50 + k);
      cyc();
    end
    cpu_wr = 1'b0;
    tx_ready = 1'b1;
    cyc();
    chk("gap.count", int'(cnt2), 3);
    chk("gap.valid", int'(txv2), 0);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("rst_gap.valid", int'(txv2), 0);
    chk("rst_gap.data", int'(txd2), 0);
    chk("rst_gap.count", int'(cnt2), 0);
    chk("rst_gap.busy", int'(busy2), 0);
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("rst_gap.no_stale", int'(txv2 || txv0), 0);
    end

    // Randomized traffic with a random ready pattern and rare flush/reset
    for (int n = 0; n < 4000; n++) begin
      cpu_wr   = ($urandom_range(0, 99) < 45);
      cpu_data = 8'($urandom);
      tx_ready = $urandom_range(0, 1) == 1;
      flush    = ($urandom_range(0, 299) == 0);
      reset    = !($urandom_range(0, 699) == 0);
      cyc();
    end
    reset = 1'b1;
    drain(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_sched.md
TX_SCHED -- requirements
Module: tx_sched

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
REQ-002 Parameter GAP_CYCLES, default 2, idle cycles inserted after each accepted byte; range 0..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low; 0 sampled at a clk edge resets the block.
REQ-005 cpu_wr  input  1  CPU output strobe; one byte offered per cycle high.
REQ-006 cpu_data  input  8  byte from CPU writedata[7:0], valid with cpu_wr.
REQ-007 flush  input  1  discard all buffered bytes.
REQ-008 tx_ready  input  1  UART transmitter can accept a byte.
REQ-009 tx_data  output  8  byte presented to transmitter.
REQ-010 tx_valid  output  1  tx_data valid; byte transfers on an edge with tx_valid&tx_ready.
REQ-011 cpu_stall  output  1  FIFO full; CPU shall hold its write.
REQ-012 fifo_count  output  $clog2(DEPTH)+1  bytes currently buffered, excluding the byte in tx_data.
REQ-013 overflow  output  1  sticky: a write was dropped.
REQ-014 busy  output  1  high when state != IDLE or fifo_count != 0.

Function
REQ-015 Byte FIFO of DEPTH entries; wrapping read/write pointers; count register 0..DEPTH.
REQ-016 Push on edge with cpu_wr=1 and count<DEPTH; cpu_data written at write pointer, pointer+1 mod DEPTH.
REQ-017 cpu_wr=1 with count=DEPTH: byte dropped, pointers/count unchanged, overflow set to 1 next edge.
REQ-018 cpu_stall = (count==DEPTH), combinational from registered count.
REQ-019 FSM states IDLE, SEND, GAP.
REQ-020 IDLE, count>0: pop head into tx_data, read pointer+1, go SEND; tx_valid=1 from that edge.
REQ-021 IDLE, count=0: stay; tx_valid=0.
REQ-022 SEND: tx_valid=1, tx_data held stable until edge with tx_ready=1.
REQ-023 SEND handshake edge: GAP_CYCLES=0 -> IDLE; else GAP with gap counter loaded GAP_CYCLES-1.
REQ-024 GAP: tx_valid=0; counter decrements each edge; at 0 go IDLE.
REQ-025 Push and pop on same edge: count unchanged, both pointers advance; push accepted even if count=DEPTH before the edge? No: push accepted only when count<DEPTH (full-and-pop edge drops the write, per REQ-017).
REQ-026 Minimum latency: cpu_wr at edge E into empty FIFO, FSM IDLE -> tx_valid=1 after edge E+1.
REQ-027 Byte order out equals accepted order in; no duplication, no loss except REQ-017/REQ-028.
REQ-028 flush=1 at an edge: pointers and count to 0, FSM to IDLE, tx_valid=0, gap counter 0; simultaneous cpu_wr ignored; overflow cleared.
REQ-029 flush during SEND abandons tx_data even without handshake; flush has priority over all other events.
REQ-030 Arithmetic on count, pointers, gap counter is unsigned; no wrap of count beyond 0 or DEPTH.

Reset
REQ-031 reset=0 at edge: tx_valid=0, tx_data=8'h00, cpu_stall=0, fifo_count=0, overflow=0, busy=0, FSM IDLE, pointers 0, gap counter 0.
REQ-032 Reset mid-SEND or mid-GAP drops all buffered and in-flight bytes; reset has priority over flush and cpu_wr.
REQ-033 FIFO storage need not be cleared by reset.

Verification
REQ-034 tx_ready=1, GAP_CYCLES=2; write 8'h41 at edge E into empty -> tx_valid=1, tx_data=8'h41 after E+1; after E+2 tx_valid=0 for 2 cycles; busy=0 after E+4.
REQ-035 tx_ready=0; write 17 bytes 8'h00..8'h10 back-to-back -> first byte moves to tx_data, fifo_count reaches 16, cpu_stall=1, 17th write accepted only if count<16 else overflow=1 and byte 8'h10 never appears.
REQ-036 tx_ready toggled 1,0,0,1 pseudo-randomly with 64 bytes, GAP_CYCLES=0 -> output stream identical to input order; tx_data never changes while tx_valid=1 and tx_ready=0.
REQ-037 FIFO full, tx_ready=1, cpu_wr=1 on the handshake edge -> write dropped, overflow=1, count goes 16->15 only after IDLE pop.
REQ-038 flush=1 with cpu_wr=1 during SEND, count=5 -> next cycle tx_valid=0, fifo_count=0, overflow=0, busy=0.
REQ-039 reset=0 while in GAP with count=3 -> all outputs at REQ-031 values next cycle; no stale byte emitted after reset=1.
